// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock LSB first,
// through a single full-subtractor cell and a borrow flop, with valid/ready handshakes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic             br;
    logic             br_next;
    logic             d;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;

    // Full-subtractor cell on the current LSBs.
    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign r_next  = {d, r[WIDTH-1:1]};

    // in_ready is gated by reset so it stays low while reset is held.
    assign in_ready  = (state == IDLE) && reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == SHIFT) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r          <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= borrow_in;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r    <= r_next;
                    br   <= br_next;
                    if (last) begin
                        diff       <= r_next;
                        borrow_out <= br_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2 against an
// arithmetic reference model (a - b - borrow_in modulo 2^WIDTH, unsigned compare).
module tb_serial_subtractor;

    logic       clk;
    logic       reset;

    logic       iv8, ir8, bi8, ov8, or8, bo8, busy8;
    logic [7:0] a8, b8, d8;
    logic       iv2, ir2, bi2, ov2, or2, bo2, busy2;
    logic [1:0] a2, b2, d2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .borrow_in(bi8), .out_valid(ov8), .out_ready(or8), .diff(d8),
        .borrow_out(bo8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .borrow_in(bi2), .out_valid(ov2), .out_ready(or2), .diff(d2),
        .borrow_out(bo2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation: accept, verify latency, result, stability under stall, handshake.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbi, input int stall);
        int         n;
        logic [7:0] ed;
        logic       eb;
        ed = 8'(int'(ta) - int'(tb_) - int'(tbi));
        eb = (int'(ta) < int'(tb_) + int'(tbi));
        n = 0;
        while (!ir8 && n < 50) begin @(negedge clk); n++; end
        check("ready8", ir8, 1);
        a8 = ta; b8 = tb_; bi8 = tbi; iv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < 40) begin @(negedge clk); n++; end
        check("latency8", n, 8);
        check("diff8", d8, ed);
        check("borrow8", bo8, eb);
        repeat (stall) begin
            @(negedge clk);
            check("stall8", {ov8, bo8, d8}, {1'b1, eb, ed});
        end
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check("ack8", ov8, 0);
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tbi, input int stall);
        int         n;
        logic [1:0] ed;
        logic       eb;
        ed = 2'(int'(ta) - int'(tb_) - int'(tbi));
        eb = (int'(ta) < int'(tb_) + int'(tbi));
        n = 0;
        while (!ir2 && n < 50) begin @(negedge clk); n++; end
        check("ready2", ir2, 1);
        a2 = ta; b2 = tb_; bi2 = tbi; iv2 = 1'b1; or2 = 1'b0;
        @(negedge clk);
        iv2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        n = 0;
        while (!ov2 && n < 40) begin @(negedge clk); n++; end
        check("latency2", n, 2);
        check("result2", {bo2, d2}, {eb, ed});
        repeat (stall) @(negedge clk);
        check("stall2", {ov2, bo2, d2}, {1'b1, eb, ed});
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
        check("ack2", ov2, 0);
    endtask

    initial begin
        int t1;
        int t2;
        int n;
        logic seen;

        reset = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0; or8 = 1'b0;
        iv2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0; or2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs8", {ir8, ov8, bo8, busy8, d8}, '0);
        check("reset_outs2", {ir2, ov2, bo2, busy2, d2}, '0);
        reset = 1'b1;
        #1;
        check("ready_after_reset", ir8, 1);

        // Idle with in_valid low: nothing moves.
        repeat (4) @(negedge clk);
        check("idle_hold", {ir8, busy8, ov8}, 3'b100);

        // Directed basic and underflow cases.
        op8(8'h5A, 8'h23, 1'b0, 0);
        check("basic_const", {bo8, d8}, {1'b0, 8'h37});
        op8(8'h10, 8'h20, 1'b0, 1);
        check("under1_const", {bo8, d8}, {1'b1, 8'hF0});
        op8(8'h00, 8'h00, 1'b1, 0);
        check("under2_const", {bo8, d8}, {1'b1, 8'hFF});
        op8(8'hFF, 8'hFF, 1'b1, 2);
        check("under3_const", {bo8, d8}, {1'b1, 8'hFF});

        // Backpressure: operands wiggle with in_valid high while the result is held.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin @(negedge clk); n++; end
        check("bp_latency", n, 8);
        repeat (5) begin
            a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
            @(negedge clk);
            check("bp_hold", {ov8, bo8, d8}, {1'b1, 1'b0, 8'h37});
            check("bp_flags", {ir8, busy8}, 2'b01);
        end
        or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b0;
        check("bp_release", {ov8, ir8}, 2'b01);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        t1 = cyc;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02;
        n = 0;
        while (!ir8 && n < 40) begin
            if (ov8) check("b2b_first", {bo8, d8}, {1'b0, 8'h37});
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 10);
        @(negedge clk);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin @(negedge clk); n++; end
        check("b2b_second", {ov8, bo8, d8}, {1'b1, 1'b1, 8'hFF});
        @(negedge clk);
        or8 = 1'b0;

        // Reset pulse during the third SHIFT cycle aborts the operation.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midop_reset_outs", {ir8, ov8, bo8, busy8, d8}, '0);
        @(negedge clk);
        check("midop_reset_hold", {ir8, ov8, bo8, busy8, d8}, '0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        check("no_partial_result", seen, 0);
        op8(8'h80, 8'h01, 1'b0, 0);
        check("fresh_const", {bo8, d8}, {1'b0, 8'h7F});

        // WIDTH=2 corner cases, then random sweeps at both widths.
        op2(2'b00, 2'b00, 1'b1, 0);
        op2(2'b11, 2'b01, 1'b0, 1);
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        for (int i = 0; i < 1000; i++)
            op2(2'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
